// File: rtl/moore_seq_fsm_if.sv
// Handshake-free control bundle for moore_seq_fsm: sequence controls in, state/status out.
// Latency: n/a (wires only).  Backpressure: none; outputs are always valid.
// Ports: master drives start/abort/skip_mask[/hold] and observes out/busy/done/seq_cnt;
//        slave is the sequencer side. hold exists only when SEQ_HOLD_EN is defined.
interface moore_seq_fsm_if #(
    parameter int NUM_ST = 4,
    parameter int SW     = 2,
    parameter int CW     = 8
);
    logic              start;
    logic              abort;
    logic [NUM_ST-1:0] skip_mask;
`ifdef SEQ_HOLD_EN
    logic              hold;
`endif
    logic [SW-1:0]     out;
    logic              busy;
    logic              done;
    logic [CW-1:0]     seq_cnt;

`ifdef SEQ_HOLD_EN
    modport master (output start, abort, skip_mask, hold,
                    input  out, busy, done, seq_cnt);
    modport slave  (input  start, abort, skip_mask, hold,
                    output out, busy, done, seq_cnt);
`else
    modport master (output start, abort, skip_mask,
                    input  out, busy, done, seq_cnt);
    modport slave  (input  start, abort, skip_mask,
                    output out, busy, done, seq_cnt);
`endif
endinterface

// File: rtl/moore_seq_fsm.sv
// Moore sequencer stepping idle -> unskipped middle states -> last -> idle, counting completed runs.
// Latency: one clock per step; out/busy/done are registered, no input-to-output path.
// Backpressure: none; abort > hold > normal step. Optional hold input enabled by macro SEQ_HOLD_EN.
// Ports: clk, reset (async active-low), bus (moore_seq_fsm_if.slave):
//        start, abort, skip_mask[NUM_ST], hold (SEQ_HOLD_EN only) in; out[SW], busy, done, seq_cnt[CW] out.
module moore_seq_fsm #(
    parameter int NUM_ST = 4,
    parameter int SW     = 2,
    parameter int CW     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    moore_seq_fsm_if.slave       bus
);

    // The state is a plain index (parametric count), and the index itself is the output.
    typedef logic [SW-1:0] st_idx_t;

    localparam st_idx_t ST_IDLE = '0;
    localparam st_idx_t ST_LAST = SW'(NUM_ST - 1);

    st_idx_t       st;
    st_idx_t       nxt;
    logic          cnt_inc;
    logic          busy_q;
    logic          done_q;
    logic [CW-1:0] cnt_q;

    // Smallest middle index above cur that is not skipped; falls through to the last state.
    function automatic st_idx_t first_after(input st_idx_t cur, input logic [NUM_ST-1:0] mk);
        st_idx_t res;
        res = ST_LAST;
        // Descending scan so the smallest qualifying index wins.
        for (int j = NUM_ST - 2; j >= 1; j--) begin
            if ((SW'(j) > cur) && !mk[j]) begin
                res = SW'(j);
            end
        end
        return res;
    endfunction

    always_comb begin
        nxt     = st;
        cnt_inc = 1'b0;
        if (bus.abort) begin
            nxt = ST_IDLE;
        end
`ifdef SEQ_HOLD_EN
        else if (bus.hold) begin
            nxt = st;
        end
`endif
        else if (st == ST_IDLE) begin
            nxt = bus.start ? first_after(ST_IDLE, bus.skip_mask) : ST_IDLE;
        end
        else if (st < ST_LAST) begin
            nxt = first_after(st, bus.skip_mask);
        end
        else if (st == ST_LAST) begin
            nxt     = ST_IDLE;
            cnt_inc = 1'b1;
        end
        else begin
            // Encodings past the last state are unreachable; recover to idle.
            nxt = ST_IDLE;
        end
    end

    // busy/done are registered from the next state so they line up with out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st     <= ST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            st     <= nxt;
            busy_q <= (nxt != ST_IDLE);
            done_q <= (nxt == ST_LAST);
            if (cnt_inc) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign bus.out     = st;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.seq_cnt = cnt_q;

    // The end bits of skip_mask carry no meaning: idle and last can never be bypassed.
    logic unused_mask_ends;
    assign unused_mask_ends = bus.skip_mask[0] ^ bus.skip_mask[NUM_ST-1];

endmodule

// File: tb/tb_moore_seq_fsm.sv
// Bench for moore_seq_fsm: two instances (4 states / 2-bit counter, 8 states / 8-bit counter)
// share start/abort/hold; each has its own skip_mask. Expected outputs are queued per edge
// and compared by an independent monitor after each rising edge.
module tb_moore_seq_fsm;

    localparam int NA = 4;
    localparam int NB = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
`ifdef SEQ_HOLD_EN
    logic hold = 1'b0;
`endif
    logic [NA-1:0] mask_a = '0;
    logic [NB-1:0] mask_b = '0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    moore_seq_fsm_if #(.NUM_ST(NA), .SW(2), .CW(2)) ifa ();
    moore_seq_fsm_if #(.NUM_ST(NB), .SW(3), .CW(8)) ifb ();

    assign ifa.start     = start;
    assign ifa.abort     = abort;
    assign ifa.skip_mask = mask_a;
    assign ifb.start     = start;
    assign ifb.abort     = abort;
    assign ifb.skip_mask = mask_b;
`ifdef SEQ_HOLD_EN
    assign ifa.hold = hold;
    assign ifb.hold = hold;
`endif

    moore_seq_fsm #(.NUM_ST(NA), .SW(2), .CW(2)) u_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    moore_seq_fsm #(.NUM_ST(NB), .SW(3), .CW(8)) u_b (.clk(clk), .reset(reset), .bus(ifb.slave));

    typedef struct {
        int o;
        int b;
        int d;
        int c;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    // Reference model state: plain integers.
    int ma_st = 0, ma_cnt = 0;
    int mb_st = 0, mb_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // First non-bypassed state after i; the last state if every middle one is bypassed.
    function automatic int first_after(input int i, input int n, input logic [15:0] mk);
        for (int j = i + 1; j <= n - 2; j++) begin
            if (!mk[j]) return j;
        end
        return n - 1;
    endfunction

    function automatic int model_next(input int s_now, input int n, input logic [15:0] mk,
                                      input bit s, input bit ab, input bit hd);
        if (ab) return 0;
        if (hd) return s_now;
        if (s_now == 0) return s ? first_after(0, n, mk) : 0;
        if (s_now >= n - 1) return 0;
        return first_after(s_now, n, mk);
    endfunction

    // One clock of stimulus; the model predicts the outputs visible after the next edge.
    task automatic step(input bit s, input bit ab, input bit hd,
                        input logic [NA-1:0] mka, input logic [NB-1:0] mkb);
        bit   h_eff;
        int   na_st, nb_st;
        exp_t e;
        @(negedge clk);
        start  = s;
        abort  = ab;
        mask_a = mka;
        mask_b = mkb;
`ifdef SEQ_HOLD_EN
        hold  = hd;
        h_eff = hd;
`else
        h_eff = 1'b0;
        if (hd) h_eff = 1'b0;
`endif
        na_st = model_next(ma_st, NA, 16'(mka), s, ab, h_eff);
        nb_st = model_next(mb_st, NB, 16'(mkb), s, ab, h_eff);
        if (!ab && !h_eff && ma_st == NA - 1) ma_cnt = (ma_cnt + 1) % 4;
        if (!ab && !h_eff && mb_st == NB - 1) mb_cnt = (mb_cnt + 1) % 256;
        ma_st = na_st;
        mb_st = nb_st;
        e.o = ma_st; e.b = (ma_st != 0); e.d = (ma_st == NA - 1); e.c = ma_cnt;
        qa.push_back(e);
        e.o = mb_st; e.b = (mb_st != 0); e.d = (mb_st == NB - 1); e.c = mb_cnt;
        qb.push_back(e);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_a_out"},  int'(ifa.out), 0);
        check({tag, "_a_busy"}, int'(ifa.busy), 0);
        check({tag, "_a_done"}, int'(ifa.done), 0);
        check({tag, "_a_cnt"},  int'(ifa.seq_cnt), 0);
        check({tag, "_b_out"},  int'(ifb.out), 0);
        check({tag, "_b_cnt"},  int'(ifb.seq_cnt), 0);
    endtask

    // Pull reset mid-cycle (no clock edge), then hold it across an edge with start high.
    task automatic async_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_idle("async_rst");
        ma_st = 0; ma_cnt = 0; mb_st = 0; mb_cnt = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("rst_edge_a_out", int'(ifa.out), 0);
        check("rst_edge_b_out", int'(ifb.out), 0);
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
    endtask

    // Monitor: outputs are valid every cycle once reset is released.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset && qa.size() > 0) begin
                e = qa.pop_front();
                check("a_out",  int'(ifa.out), e.o);
                check("a_busy", int'(ifa.busy), e.b);
                check("a_done", int'(ifa.done), e.d);
                check("a_cnt",  int'(ifa.seq_cnt), e.c);
            end
            if (reset && qb.size() > 0) begin
                e = qb.pop_front();
                check("b_out",  int'(ifb.out), e.o);
                check("b_busy", int'(ifb.busy), e.b);
                check("b_done", int'(ifb.done), e.d);
                check("b_cnt",  int'(ifb.seq_cnt), e.c);
            end
        end
    end

    initial begin
        logic [NA-1:0] ra;
        logic [NB-1:0] rb;
        #1;
        check_idle("por");
        @(posedge clk);
        #1;
        check_idle("por_edge");
        @(negedge clk);
        reset = 1'b1;

        step(0, 0, 0, '0, '0);
        step(0, 0, 0, '0, '0);

        // Plain run: a goes 1,2,3,0 and b walks all eight states.
        step(1, 0, 0, '0, '0);
        repeat (9) step(0, 0, 0, '0, '0);

        // Middle skip on a, then end bits only (must act like no skip).
        step(1, 0, 0, 4'b0100, '0);
        repeat (3) step(0, 0, 0, 4'b0100, '0);
        step(1, 0, 0, 4'b1001, '0);
        repeat (4) step(0, 0, 0, 4'b1001, '0);

        // All middle states of b bypassed: 0 -> 7 -> 0 with one count.
        repeat (6) step(0, 0, 0, '0, 8'b0111_1110);
        step(1, 0, 0, 4'b0110, 8'b0111_1110);
        repeat (3) step(0, 0, 0, 4'b0110, 8'b0111_1110);

        // Abort while a sits in its last state.
        step(1, 0, 0, '0, '0);
        step(0, 0, 0, '0, '0);
        step(0, 0, 0, '0, '0);
        step(0, 1, 0, '0, '0);
        step(0, 0, 0, '0, '0);

        // Five back-to-back sequences on a: 2-bit counter wraps.
        repeat (5) begin
            step(1, 0, 0, '0, '0);
            repeat (3) step(0, 0, 0, '0, '0);
        end
        repeat (8) step(0, 0, 0, '0, '0);

        // Hold at state 2 for three cycles, resume, then hold together with abort.
        step(1, 0, 0, '0, '0);
        step(0, 0, 0, '0, '0);
        repeat (3) step(0, 0, 1, '0, '0);
        step(0, 0, 0, '0, '0);
        step(0, 0, 0, '0, '0);
        step(1, 0, 0, '0, '0);
        step(0, 1, 1, '0, '0);
        step(0, 0, 0, '0, '0);

        // Reset mid-sequence, then the block waits for start.
        step(1, 0, 0, '0, '0);
        step(0, 0, 0, '0, '0);
        async_reset();
        step(0, 0, 0, '0, '0);
        step(0, 0, 0, '0, '0);

        // Randomized traffic with masks changing mid-sequence.
        ra = '0;
        rb = '0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) ra = NA'($urandom);
            if ($urandom_range(0, 3) == 0) rb = NB'($urandom);
            if ($urandom_range(0, 15) == 0) rb = '1;
            step($urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 7) == 0, ra, rb);
        end

        step(0, 0, 0, '0, '0);
        repeat (2) @(posedge clk);
        #2;
        check("queue_drained", qa.size() + qb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/moore_seq_fsm.md
MOORE_SEQ_FSM -- requirements
Module: moore_seq_fsm

Interface
REQ-001 SHALL provide parameter NUM_ST, default 4, number of sequence states (legal 3..16); index 0 is idle, index NUM_ST-1 is last.
REQ-002 SHALL provide parameter SW, default 2, state/output width (SHALL satisfy 2**SW >= NUM_ST).
REQ-003 SHALL provide parameter CW, default 8, completed-sequence counter width.
REQ-004 clk  input  1  single clock, all flops on posedge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  leave idle (state 0) when high.
REQ-007 abort  input  1  return to idle on next edge.
REQ-008 skip_mask  input  NUM_ST  bit j high = state j bypassed; bits 0 and NUM_ST-1 ignored.
REQ-009 hold  input  1  freeze state (present only with SEQ_HOLD_EN).
REQ-010 out  output  SW  current state index (Moore, registered state).
REQ-011 busy  output  1  high when state != 0.
REQ-012 done  output  1  high when state == NUM_ST-1.
REQ-013 seq_cnt  output  CW  number of completed sequences, modulo 2**CW.

Function
REQ-014 out, busy, done SHALL depend only on the state register; no input-to-output combinational path.
REQ-015 State 0: start=1 -> next = smallest j>=1 with skip_mask[j]=0; start=0 -> stay 0.
REQ-016 State i, 0<i<NUM_ST-1: next = smallest j>i with skip_mask[j]=0; if none, NUM_ST-1; start ignored.
REQ-017 State NUM_ST-1: next = 0 unconditionally; seq_cnt increments by 1 on that edge.
REQ-018 skip_mask SHALL be sampled in the cycle of each transition (changes mid-sequence take effect on the next step).
REQ-019 All-skipped middle states: 0 -> NUM_ST-1 -> 0 (two transitions, one count).
REQ-020 abort=1 SHALL force next = 0 from any state; seq_cnt SHALL NOT increment, including when abort occurs in the last state.
REQ-021 Priority: reset > abort > hold > normal transition.
REQ-022 seq_cnt SHALL wrap from 2**CW-1 to 0 without flag.
REQ-023 State encodings >= NUM_ST (unreachable) SHALL transition to 0 on the next edge.
REQ-024 Latency: one clock per step; state change visible on out the cycle after the enabling edge.

Reset
REQ-025 reset low SHALL asynchronously set state=0, out=0, busy=0, done=0, seq_cnt=0, irrespective of clk.
REQ-026 reset asserted mid-sequence SHALL discard progress; after release the block waits in idle for start.
REQ-027 First state change after reset release SHALL occur only on a posedge with reset high.

Configuration
REQ-028 Macro SEQ_HOLD_EN defined: hold port exists; hold=1 (and abort=0) keeps state and seq_cnt unchanged, including in state 0 with start=1 and in the last state.
REQ-029 Macro SEQ_HOLD_EN undefined: hold port absent; behaviour identical to hold tied 0.

Verification
REQ-030 NUM_ST=4, skip_mask=0, start pulse 1 cycle -> out 0,1,2,3,0 on successive cycles, done high only at 3, seq_cnt 0->1.
REQ-031 NUM_ST=4, skip_mask=4'b0100, start -> out 0,1,3,0; skip_mask=4'b1001 behaves as 0 (ends ignored).
REQ-032 NUM_ST=8, skip_mask=8'b0111_1110, start -> out 0,7,0; seq_cnt +1.
REQ-033 abort asserted while out=3 (NUM_ST=4) -> out 0 next cycle, seq_cnt unchanged; reset low while out=2 -> out=0, seq_cnt=0 immediately without clock.
REQ-034 CW=2, run 5 full sequences -> seq_cnt 1,2,3,0,1.
REQ-035 SEQ_HOLD_EN defined, hold=1 for 3 cycles at out=2 -> out stays 2, then resumes 3,0; abort with hold=1 -> out 0.
